// File: rtl/if_id_stage.sv
// if_id_stage: elastic IF/ID pipeline register for the pipelined MIPS core.
// A main entry drives the decode-side outputs directly and a skid entry
// absorbs the one beat that can arrive after decode stalls, so in_ready can
// come straight from a flop while still sustaining one beat per cycle.
// A synchronous flush squashes both entries on a branch/jump redirect.
// Optional feature macro: IF_ID_BUBBLE_COUNT_EN adds the bubble_count port,
// a saturating count of cycles where decode was ready but no beat was valid.
module if_id_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0] in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_instr
`ifdef IF_ID_BUBBLE_COUNT_EN
  ,
  output logic [15:0]           bubble_count
`endif
);

  logic                  main_v_q, main_v_d;
  logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
  logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
  logic                  skid_v_q, skid_v_d;
  logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;

  logic accept_s;
  logic consume_s;

  // Handshake qualifiers; in_ready is taken from the skid flop only.
  always_comb begin
    in_ready  = !skid_v_q;
    accept_s  = in_valid && !skid_v_q;
    consume_s = main_v_q && out_ready;
  end

  // Next-state of the two entries, evaluated in priority order: flush,
  // main free (empty or drained this cycle), main stalled.
  always_comb begin
    main_v_d     = main_v_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      // Squash everything; the beat offered this cycle is dropped too.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || consume_s) begin
      if (skid_v_q) begin
        // Older skid beat moves up first to keep FIFO order.
        main_v_d     = 1'b1;
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
        if (accept_s) begin
          skid_v_d     = 1'b1;
          skid_pc_d    = in_pc;
          skid_instr_d = in_instr;
        end else begin
          skid_v_d = 1'b0;
        end
      end else if (accept_s) begin
        main_v_d     = 1'b1;
        main_pc_d    = in_pc;
        main_instr_d = in_instr;
        skid_v_d     = 1'b0;
      end else begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end
    end else begin
      // Main is stalled: a newly accepted beat parks in the skid entry.
      if (accept_s) begin
        skid_v_d     = 1'b1;
        skid_pc_d    = in_pc;
        skid_instr_d = in_instr;
      end else begin
        skid_v_d = skid_v_q;
      end
    end
  end

  // Entry registers; reset clears valids and data so outputs read zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v_q     <= 1'b0;
      main_pc_q    <= {PC_WIDTH{1'b0}};
      main_instr_q <= {DATA_WIDTH{1'b0}};
      skid_v_q     <= 1'b0;
      skid_pc_q    <= {PC_WIDTH{1'b0}};
      skid_instr_q <= {DATA_WIDTH{1'b0}};
    end else begin
      main_v_q     <= main_v_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Decode side sees the main entry directly.
  always_comb begin
    out_valid = main_v_q;
    out_pc    = main_pc_q;
    out_instr = main_instr_q;
  end

`ifdef IF_ID_BUBBLE_COUNT_EN
  logic [15:0] bubble_q, bubble_d;

  // Count decode-ready-but-idle cycles, saturating; flush does not clear it.
  always_comb begin
    if (out_ready && !main_v_q && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // Bubble counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q <= 16'd0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  // Counter is exported from its flop.
  always_comb begin
    bubble_count = bubble_q;
  end
`endif

endmodule
